data_mem_dma: RTL and testbench

Block-copy engine and port owner for the 256×8 data memory. It sits directly upstream of the data memory and multiplexes the CPU load/store port with its own accesses. On a Start pulse it copies Len bytes from SrcAddr to DstAddr, two cycles per byte, while asserting Busy so the CPU stalls.

---
 rtl/data_mem_dma_pkg.sv | 21 ++
 rtl/data_mem_dma_dmem_port_mux.sv | 29 ++
 rtl/data_mem_dma.sv | 109 ++++++++++
 tb/tb_data_mem_dma.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_dma_pkg                                                       |
// | Shared widths, memory depth and copy-engine state encoding.            |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package data_mem_dma_pkg;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_dma_dmem_port_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_port_mux                                                          |
// | Selects CPU or copy engine as the owner of the data memory port.       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module dmem_port_mux #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          sel_engine,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  input  logic          eng_we,
  input  logic [AW-1:0] eng_addr,
  input  logic [DW-1:0] eng_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data
);

  // CPU stores are dropped simply by not being selected while the engine runs.
  assign mem_we   = sel_engine ? eng_we   : cpu_we;
  assign mem_addr = sel_engine ? eng_addr : cpu_addr;
  assign mem_data = sel_engine ? eng_data : cpu_data;

endmodule
`default_nettype wire

// File: rtl/data_mem_dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_dma                                                           |
// | Forward byte-copy engine that owns the data memory port.               |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module data_mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [7:0]    Len,
  input  logic          CpuWriteEn,
  input  logic [AW-1:0] CpuAddress,
  input  logic [DW-1:0] CpuDataIn,
  output logic [DW-1:0] CpuDataOut,
  output logic          Busy,
  output logic          Done,
  output logic          MemWriteEn,
  output logic [AW-1:0] MemAddress,
  output logic [DW-1:0] MemDataIn,
  input  logic [DW-1:0] MemDataOut
);

  import data_mem_dma_pkg::*;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [7:0]    r_count;
  logic [DW-1:0] r_buf;
  logic          w_accept;
  logic          w_eng_we;
  logic [AW-1:0] w_eng_addr;

  assign w_accept = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_next = (Len != 8'd0) ? ST_READ : ST_DONE;
        else          w_next = ST_IDLE;
      end
      ST_READ:  w_next = ST_WRITE;
      ST_WRITE: w_next = (r_count == 8'd1) ? ST_DONE : ST_READ;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept && (Len != 8'd0)) begin
            r_src   <= SrcAddr;
            r_dst   <= DstAddr;
            r_count <= Len;
          end
        end
        ST_READ: begin
          r_buf <= MemDataOut;
          r_src <= r_src + AW'(1);
        end
        ST_WRITE: begin
          r_dst   <= r_dst + AW'(1);
          r_count <= r_count - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign Busy       = (r_state == ST_READ) || (r_state == ST_WRITE);
  assign Done       = (r_state == ST_DONE);
  assign w_eng_we   = (r_state == ST_WRITE);
  assign w_eng_addr = (r_state == ST_WRITE) ? r_dst : r_src;
  assign CpuDataOut = MemDataOut;

  dmem_port_mux #(
    .AW (AW),
    .DW (DW)
  ) u_port_mux (
    .sel_engine (Busy),
    .cpu_we     (CpuWriteEn),
    .cpu_addr   (CpuAddress),
    .cpu_data   (CpuDataIn),
    .eng_we     (w_eng_we),
    .eng_addr   (w_eng_addr),
    .eng_data   (r_buf),
    .mem_we     (MemWriteEn),
    .mem_addr   (MemAddress),
    .mem_data   (MemDataIn)
  );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_dma                                                        |
// | Scoreboard bench: reference memory model plus Done/Busy timing queue.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_data_mem_dma;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Len;
  logic       CpuWriteEn;
  logic [7:0] CpuAddress, CpuDataIn, CpuDataOut;
  logic       Busy, Done;
  logic       MemWriteEn;
  logic [7:0] MemAddress, MemDataIn, MemDataOut;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  typedef struct {
    int done_cyc;
    int busy_len;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int run    = 0;

  data_mem_dma #(.AW(8), .DW(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Len        (Len),
    .CpuWriteEn (CpuWriteEn),
    .CpuAddress (CpuAddress),
    .CpuDataIn  (CpuDataIn),
    .CpuDataOut (CpuDataOut),
    .Busy       (Busy),
    .Done       (Done),
    .MemWriteEn (MemWriteEn),
    .MemAddress (MemAddress),
    .MemDataIn  (MemDataIn),
    .MemDataOut (MemDataOut)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Data memory: synchronous write, combinational read.
  always @(posedge Clk) if (MemWriteEn) mem[MemAddress] <= MemDataIn;
  assign MemDataOut = mem[MemAddress];

  // Monitor: every Done pulse must match the oldest expected completion.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) run = 0;
    else begin
      if (Busy) run++;
      if (Done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: Done at cycle %0d, none expected", cyc);
        end else begin
          e = q.pop_front();
          if (e.done_cyc != cyc || e.busy_len != run) begin
            errors++;
            $display("FAIL done_timing: done_cyc=%0d busy=%0d, expected done_cyc=%0d busy=%0d",
                     cyc, run, e.done_cyc, e.busy_len);
          end
        end
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] si, di;
    si = s; di = d;
    for (int i = 0; i < n; i++) begin
      ref_mem[di] = ref_mem[si];
      si = si + 8'd1;
      di = di + 8'd1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    int first;
    bad = 0; first = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes differ, first at %0d got %0d expected %0d",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  task automatic cpu_store(input logic [7:0] a, input logic [7:0] d);
    CpuWriteEn = 1'b1; CpuAddress = a; CpuDataIn = d;
    ref_mem[a] = d;
    tick();
    CpuWriteEn = 1'b0;
  endtask

  task automatic cpu_load(input string name, input logic [7:0] a);
    CpuAddress = a;
    #1;
    check(name, int'(CpuDataOut), int'(ref_mem[a]));
  endtask

  // Issues a copy and returns in the DONE cycle. noise: 0 quiet, 1 random
  // Start/store attempts while busy, 2 repeated store of FF to address 50.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input int n,
                          input bit with_wr, input int noise);
    exp_t e;
    Start = 1'b1; SrcAddr = s; DstAddr = d; Len = 8'(n);
    if (with_wr) begin
      CpuWriteEn = 1'b1;
      CpuAddress = 8'($urandom);
      CpuDataIn  = 8'($urandom);
      ref_mem[CpuAddress] = CpuDataIn;
    end
    model_copy(s, d, n);
    e.done_cyc = cyc + 1 + 2 * n;
    e.busy_len = 2 * n;
    q.push_back(e);
    tick();
    Start = 1'b0; CpuWriteEn = 1'b0;
    for (int i = 0; i < 2 * n; i++) begin
      if (noise == 1) begin
        Start      = ($urandom_range(0, 2) == 0);
        SrcAddr    = 8'($urandom);
        DstAddr    = 8'($urandom);
        Len        = 8'($urandom_range(1, 5));
        CpuWriteEn = ($urandom_range(0, 1) == 1);
        CpuAddress = 8'($urandom);
        CpuDataIn  = 8'($urandom);
      end else if (noise == 2) begin
        CpuWriteEn = 1'b1; CpuAddress = 8'd50; CpuDataIn = 8'hFF;
      end
      tick();
    end
    Start = 1'b0; CpuWriteEn = 1'b0;
    check_mem("copy_memory");
  endtask

  initial begin
    logic [7:0] s, d;
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
    CpuWriteEn = 1'b0; CpuAddress = '0; CpuDataIn = '0;
    tick(); tick();
    Reset = 1'b0;
    check("reset_busy", int'(Busy), 0);
    check("reset_done", int'(Done), 0);
    CpuAddress = 8'd77; CpuDataIn = 8'h3C; CpuWriteEn = 1'b1;
    #1;
    check("idle_mux_addr", int'(MemAddress), 77);
    check("idle_mux_we", int'(MemWriteEn), 1);
    CpuWriteEn = 1'b0;

    cpu_store(8'd3, 8'hA5);
    cpu_load("idle_load", 8'd3);

    // Basic copy.
    for (int i = 0; i < 4; i++) cpu_store(8'(10 + i), 8'(i + 1));
    run_copy(8'd10, 8'd40, 4, 1'b0, 0);
    tick();
    cpu_load("basic_dst40", 8'd40);
    cpu_load("basic_dst43", 8'd43);

    // Wrap and overlap.
    cpu_store(8'd254, 8'd9); cpu_store(8'd255, 8'd8);
    cpu_store(8'd0, 8'd7);   cpu_store(8'd1, 8'd6);
    run_copy(8'd254, 8'd1, 4, 1'b0, 0);
    tick();
    check("wrap_a1", int'(mem[1]), 9);
    check("wrap_a2", int'(mem[2]), 8);
    check("wrap_a3", int'(mem[3]), 7);
    check("wrap_a4", int'(mem[4]), 9);

    // Zero length, ignored Start during a copy.
    run_copy(8'd5, 8'd6, 0, 1'b0, 0);
    tick();
    run_copy(8'd20, 8'd30, 3, 1'b0, 1);
    tick();

    // Dropped CPU store while busy.
    cpu_store(8'd50, 8'h33);
    run_copy(8'd60, 8'd70, 3, 1'b0, 2);
    tick();
    cpu_load("dropped_store50", 8'd50);

    // Start with simultaneous CPU store: the copy reads the new value.
    CpuWriteEn = 1'b1; CpuAddress = 8'd90; CpuDataIn = 8'h5E; ref_mem[90] = 8'h5E;
    Start = 1'b1; SrcAddr = 8'd90; DstAddr = 8'd91; Len = 8'd1;
    model_copy(8'd90, 8'd91, 1);
    q.push_back('{done_cyc: cyc + 3, busy_len: 2});
    tick();
    Start = 1'b0; CpuWriteEn = 1'b0;
    tick(); tick();
    check_mem("start_with_store");
    tick();

    // Reset mid-copy after one byte has been written.
    for (int i = 0; i < 4; i++) cpu_store(8'(100 + i), 8'(200 + i));
    Start = 1'b1; SrcAddr = 8'd100; DstAddr = 8'd110; Len = 8'd4;
    model_copy(8'd100, 8'd110, 1);
    tick();
    Start = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_busy", int'(Busy), 0);
    check("abort_done", int'(Done), 0);
    check_mem("abort_memory");
    run_copy(8'd100, 8'd110, 4, 1'b0, 0);
    tick();

    // Randomized copies, including back-to-back starts from DONE.
    for (int k = 0; k < 30; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        cpu_store(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) cpu_load("rand_load", 8'($urandom));
      s = 8'($urandom); d = 8'($urandom); n = int'($urandom_range(0, 12));
      run_copy(s, d, n, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 1)));
      if (($urandom_range(0, 1) == 1)) begin
        run_copy(8'($urandom), 8'($urandom), int'($urandom_range(1, 8)), 1'b0, 0);
      end
      tick();
    end

    tick(); tick();
    check("pending_done_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
